// File: rtl/ritc_lane_align.sv
// ritc_lane_align: automatic per-lane bitslip training over deserialized RITC lanes.
// Lanes are trained one at a time, slipping until the word matches PATTERN or MAX_SLIP runs out.
module ritc_lane_align #(
   parameter int               NCH        = 6,
   parameter int               NBIT       = 12,
   parameter int               NSAMP      = 4,
   parameter logic [NSAMP-1:0] PATTERN    = 4'b1100,
   parameter int               SETTLE_CYC = 16,
   parameter int               MATCH_CNT  = 64,
   parameter int               MAX_SLIP   = 8,
   localparam int              NLANE      = NCH * NBIT,
   localparam int              LW         = (NLANE > 1) ? $clog2(NLANE) : 1
) (
   input  logic                   SYSCLK,
   input  logic                   RESET,
   input  logic                   START,
   input  logic [NLANE*NSAMP-1:0] CH_DAT,
   output logic [NLANE-1:0]       BITSLIP,
   output logic                   TRAIN_ON,
   output logic                   BUSY,
   output logic                   DONE,
   output logic [NLANE-1:0]       LOCKED,
   output logic [NLANE-1:0]       FAILED,
   output logic [LW-1:0]          CUR_LANE
);

   localparam int SW = $clog2(MAX_SLIP + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_NEXT, S_FINISH
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       settle_q, settle_d;
   logic [15:0]      match_q, match_d, match_inc;
   logic [SW-1:0]    slip_q, slip_d;
   logic [LW-1:0]    lane_q, lane_d;
   logic [NLANE-1:0] locked_q, locked_d, failed_q, failed_d, bitslip_q, bitslip_d;
   logic             train_q, train_d, busy_q, busy_d, done_q, done_d;
   logic [NSAMP-1:0] lane_word;

   // START is a one-cycle request with no backpressure: accepted only in IDLE, ignored elsewhere.
   assign lane_word = CH_DAT[lane_q*NSAMP +: NSAMP];
   assign match_inc = match_q + 16'd1;

   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      match_d   = match_q;
      slip_d    = slip_q;
      lane_d    = lane_q;
      locked_d  = locked_q;
      failed_d  = failed_q;
      bitslip_d = '0;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               locked_d = '0;
               failed_d = '0;
               lane_d   = '0;
               slip_d   = '0;
               settle_d = 8'(SETTLE_CYC);
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (settle_q == 8'd0) begin
               match_d = '0;
               state_d = S_CHECK;
            end else begin
               settle_d = settle_q - 8'd1;
            end
         end
         S_CHECK: begin
            if (lane_word == PATTERN) begin
               match_d = match_inc;
               if (match_inc == 16'(MATCH_CNT)) begin
                  locked_d[lane_q] = 1'b1;
                  state_d          = S_NEXT;
               end
            end else if (slip_q < SW'(MAX_SLIP)) begin
               state_d = S_SLIP;
            end else begin
               failed_d[lane_q] = 1'b1;
               state_d          = S_NEXT;
            end
         end
         S_SLIP: begin
            slip_d   = slip_q + SW'(1);
            settle_d = 8'(SETTLE_CYC);
            state_d  = S_SETTLE;
         end
         S_NEXT: begin
            if (lane_q == LW'(NLANE - 1)) begin
               state_d = S_FINISH;
            end else begin
               lane_d   = lane_q + LW'(1);
               slip_d   = '0;
               settle_d = 8'(SETTLE_CYC);
               state_d  = S_SETTLE;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they appear registered, aligned with the state.
      busy_d  = (state_d != S_IDLE);
      train_d = (state_d != S_IDLE) && (state_d != S_FINISH);
      done_d  = (state_d == S_FINISH);
      for (int i = 0; i < NLANE; i++) begin
         bitslip_d[i] = (state_d == S_SLIP) && (lane_d == LW'(i));
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         settle_q  <= '0;
         match_q   <= '0;
         slip_q    <= '0;
         lane_q    <= '0;
         locked_q  <= '0;
         failed_q  <= '0;
         bitslip_q <= '0;
         train_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         match_q   <= match_d;
         slip_q    <= slip_d;
         lane_q    <= lane_d;
         locked_q  <= locked_d;
         failed_q  <= failed_d;
         bitslip_q <= bitslip_d;
         train_q   <= train_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign BITSLIP  = bitslip_q;
   assign TRAIN_ON = train_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign LOCKED   = locked_q;
   assign FAILED   = failed_q;
   assign CUR_LANE = lane_q;

endmodule

// File: tb/tb_ritc_lane_align.sv
// Bench for ritc_lane_align: two lanes whose words rotate on BITSLIP, checked against
// lane outcomes and sequence durations derived from the training rules.
module tb_ritc_lane_align;

   localparam int         S   = 4;
   localparam int         M   = 8;
   localparam int         MS  = 8;
   localparam logic [3:0] PAT = 4'b1100;

   logic       SYSCLK = 1'b0;
   logic       RESET  = 1'b1;
   logic       START  = 1'b0;
   logic [7:0] CH_DAT;
   logic [1:0] BITSLIP, LOCKED, FAILED;
   logic       TRAIN_ON, BUSY, DONE;
   logic       CUR_LANE;

   int errors = 0;
   int checks = 0;

   // Lane source model
   logic [3:0] init_w [2] = '{PAT, PAT};
   bit         stuck  [2] = '{1'b0, 1'b0};
   bit         frozen [2] = '{1'b0, 1'b0};
   bit         glitch = 1'b0;
   int         slips_total [2] = '{0, 0};
   int         base_total  [2] = '{0, 0};
   int         slip_log [$];
   int         onehot_bad = 0;
   int         cyc = 0;

   ritc_lane_align #(
      .NCH(1), .NBIT(2), .NSAMP(4), .PATTERN(PAT),
      .SETTLE_CYC(S), .MATCH_CNT(M), .MAX_SLIP(MS)
   ) dut (
      .SYSCLK(SYSCLK), .RESET(RESET), .START(START), .CH_DAT(CH_DAT),
      .BITSLIP(BITSLIP), .TRAIN_ON(TRAIN_ON), .BUSY(BUSY), .DONE(DONE),
      .LOCKED(LOCKED), .FAILED(FAILED), .CUR_LANE(CUR_LANE)
   );

   always #5 SYSCLK = ~SYSCLK;

   always @(posedge SYSCLK) cyc <= cyc + 1;

   function automatic logic [3:0] rotl(input logic [3:0] w, input int n);
      logic [3:0] r = w;
      for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
      return r;
   endfunction

   always_comb begin
      logic [3:0] w;
      CH_DAT = '0;
      for (int l = 0; l < 2; l++) begin
         w = rotl(init_w[l], frozen[l] ? 0 : (slips_total[l] - base_total[l]));
         if (stuck[l]) w = 4'b0000;
         if (glitch && l == 0) w = ~w;
         CH_DAT[l*4 +: 4] = w;
      end
   end

   always @(negedge SYSCLK) begin
      if (BITSLIP != 2'b00) slip_log.push_back(cyc);
      if (BITSLIP == 2'b11) onehot_bad <= onehot_bad + 1;
      for (int l = 0; l < 2; l++)
         if (BITSLIP[l]) slips_total[l] <= slips_total[l] + 1;
   end

   // Reference: number of slips until the word equals PAT, and whether the lane locks.
   task automatic lane_ref(input logic [3:0] w, input bit st, output int k, output bit lk);
      k  = MS;
      lk = 1'b0;
      if (!st) begin
         for (int j = 0; j <= MS; j++) begin
            if (rotl(w, j) == PAT) begin
               k  = j;
               lk = 1'b1;
               break;
            end
         end
      end
   endtask

   // Cycles a lane occupies: settle, per slip (bad check + slip + settle), then lock run or fail.
   function automatic int lane_time(input int k, input bit lk);
      return (S + 1) + k * (S + 3) + (lk ? (M + 1) : 2);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic run_seq(input string tag, input int mid_at, input int glitch_at,
                          input int exp_lat, input logic [1:0] exp_lock,
                          input logic [1:0] exp_fail, input int exp_k0, input int exp_k1);
      int  start_cyc, base_idx, i, min_gap;
      bit  found;
      base_total = slips_total;
      base_idx   = slip_log.size();
      @(posedge SYSCLK); #1 START = 1'b1;
      @(posedge SYSCLK); #1 START = 1'b0;
      start_cyc = cyc;
      check({tag, "_busy_up"}, BUSY, 1);
      check({tag, "_train_up"}, TRAIN_ON, 1);
      check({tag, "_clr"}, {LOCKED, FAILED}, 0);
      i = 0;
      found = 1'b0;
      while (i < 3000 && !found) begin
         @(posedge SYSCLK); #1;
         i++;
         START  = (i == mid_at);
         glitch = (i == glitch_at);
         if (DONE) found = 1'b1;
      end
      START  = 1'b0;
      glitch = 1'b0;
      check({tag, "_done_seen"}, found, 1);
      check({tag, "_latency"}, cyc - start_cyc, exp_lat);
      check({tag, "_train_fin"}, TRAIN_ON, 0);
      check({tag, "_busy_fin"}, BUSY, 1);
      check({tag, "_locked"}, LOCKED, exp_lock);
      check({tag, "_failed"}, FAILED, exp_fail);
      check({tag, "_disjoint"}, LOCKED & FAILED, 0);
      check({tag, "_slips0"}, slips_total[0] - base_total[0], exp_k0);
      check({tag, "_slips1"}, slips_total[1] - base_total[1], exp_k1);
      min_gap = 1000;
      for (int j = base_idx + 1; j < slip_log.size(); j++)
         if (slip_log[j] - slip_log[j-1] < min_gap) min_gap = slip_log[j] - slip_log[j-1];
      check({tag, "_slip_gap"}, min_gap >= S + 1, 1);
      check({tag, "_onehot"}, onehot_bad, 0);
      @(posedge SYSCLK); #1;
      check({tag, "_busy_down"}, BUSY, 0);
      check({tag, "_done_pulse"}, DONE, 0);
   endtask

   task automatic run_ref(input string tag, input int mid_at);
      int k0, k1;
      bit l0, l1;
      lane_ref(init_w[0], stuck[0], k0, l0);
      lane_ref(init_w[1], stuck[1], k1, l1);
      run_seq(tag, mid_at, 0, lane_time(k0, l0) + lane_time(k1, l1),
              {l1, l0}, {!l1, !l0}, k0, k1);
   endtask

   initial begin
      repeat (3) @(posedge SYSCLK);
      #1;
      check("rst_held", {BITSLIP, TRAIN_ON, BUSY, DONE, LOCKED, FAILED, CUR_LANE}, 0);
      RESET = 1'b0;
      @(posedge SYSCLK); #1;
      check("rst_idle", {BITSLIP, TRAIN_ON, BUSY, DONE, LOCKED, FAILED, CUR_LANE}, 0);

      // Both lanes already aligned.
      run_seq("aligned", 0, 0, 2 * (S + M + 2), 2'b11, 2'b00, 0, 0);

      // Lane 1 rotated so that three slips realign it.
      init_w[1] = rotl(PAT, 1);
      run_ref("lane1_rot", 0);

      // Lane 0 stuck low: slips exhausted, lane 1 still locks.
      init_w[1] = PAT;
      stuck[0]  = 1'b1;
      run_ref("lane0_stuck", 0);
      stuck[0]  = 1'b0;

      // One mismatch after five good checks on lane 0 (source ignores slips).
      frozen[0] = 1'b1;
      run_seq("glitch", 0, S + 1 + 5, lane_time(1, 1) + 5 + lane_time(0, 1),
              2'b11, 2'b00, 1, 0);
      frozen[0] = 1'b0;

      // START mid-sequence is ignored.
      run_seq("mid_start", 20, 0, 2 * (S + M + 2), 2'b11, 2'b00, 0, 0);

      // RESET while lane 1 settles, then a complete sequence.
      @(posedge SYSCLK); #1 START = 1'b1;
      @(posedge SYSCLK); #1 START = 1'b0;
      repeat (S + M + 4) @(posedge SYSCLK);
      #1;
      check("pre_rst_lane", CUR_LANE, 1);
      check("pre_rst_locked", LOCKED, 2'b01);
      RESET = 1'b1;
      @(posedge SYSCLK); #1;
      check("mid_rst", {BITSLIP, TRAIN_ON, BUSY, DONE, LOCKED, FAILED, CUR_LANE}, 0);
      RESET = 1'b0;
      run_seq("after_rst", 0, 0, 2 * (S + M + 2), 2'b11, 2'b00, 0, 0);

      // Random lane rotations and stuck lanes.
      for (int r = 0; r < 6; r++) begin
         for (int l = 0; l < 2; l++) begin
            init_w[l] = rotl(PAT, $urandom_range(0, 3));
            stuck[l]  = ($urandom_range(0, 3) == 0);
         end
         run_ref($sformatf("rand%0d", r), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
